// File: rtl/systolic_host_feeder_if.sv
// Host bus and target pin bundle for the systolic host feeder; no internal state.
// Host side is gated by wr_ready/busy; the target side has no backpressure.
interface systolic_host_feeder_if #(
    parameter int N = 8
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic          wr_valid;
    logic          wr_ready;
    logic          wr_sel;
    logic [N-1:0]  wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          tgt_rst_n;
    logic [N-1:0]  tgt_ui_in;
    logic          tgt_readout;
    logic [N-1:0]  tgt_uo_out;

    modport slave (
        input  wr_valid, wr_sel, wr_data, start, rd_addr, tgt_uo_out,
        output wr_ready, busy, done, rd_data, tgt_rst_n, tgt_ui_in, tgt_readout
    );

    modport master (
        output wr_valid, wr_sel, wr_data, start, rd_addr, tgt_uo_out,
        input  wr_ready, busy, done, rd_data, tgt_rst_n, tgt_ui_in, tgt_readout
    );
endinterface

// File: rtl/systolic_host_feeder.sv
// Buffers A/B operands, resets the target tile, streams A/B pairs, flushes, then captures N results.
// A run takes 1+2K+2*FLUSH_PAIRS+CAP_DLY+N+1 cycles; host writes and start are refused while busy.
module systolic_host_feeder #(
    parameter int N           = 8,
    parameter int K           = 8,
    parameter int FLUSH_PAIRS = 16,
    parameter int CAP_DLY     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    systolic_host_feeder_if.slave bus
);
    localparam int AW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = (K > 1) ? $clog2(K) : 1;
    localparam int M1   = (2 * K > 2 * FLUSH_PAIRS) ? 2 * K : 2 * FLUSH_PAIRS;
    localparam int M2   = (CAP_DLY > N) ? CAP_DLY : N;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_FEED,
        S_FLUSH,
        S_RDWAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam state_t AFTER_FLUSH = (CAP_DLY > 0) ? S_RDWAIT : S_CAPTURE;
    localparam state_t AFTER_FEED  = (FLUSH_PAIRS > 0) ? S_FLUSH : AFTER_FLUSH;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ptr_a_q, ptr_a_d;
    logic [PW-1:0] ptr_b_q, ptr_b_d;
    logic [N-1:0]  a_q [K];
    logic [N-1:0]  a_d [K];
    logic [N-1:0]  b_q [K];
    logic [N-1:0]  b_d [K];
    logic [N-1:0]  res_q [N];
    logic [N-1:0]  res_d [N];

    logic          wr_ready_q, wr_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tgt_rst_n_q, tgt_rst_n_d;
    logic [N-1:0]  tgt_ui_in_q, tgt_ui_in_d;
    logic          tgt_readout_q, tgt_readout_d;
    logic [PW-1:0] feed_idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_a_d  = ptr_a_q;
        ptr_b_d  = ptr_b_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        feed_idx = '0;

        case (state_q)
            S_IDLE: begin
                // wr_ready_q is low for the first cycle out of reset, so it gates writes too
                if (bus.wr_valid && wr_ready_q) begin
                    if (bus.wr_sel) begin
                        b_d[ptr_b_q] = bus.wr_data;
                        ptr_b_d      = (ptr_b_q == PW'(K - 1)) ? '0 : ptr_b_q + PW'(1);
                    end else begin
                        a_d[ptr_a_q] = bus.wr_data;
                        ptr_a_d      = (ptr_a_q == PW'(K - 1)) ? '0 : ptr_a_q + PW'(1);
                    end
                end
                if (bus.start) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                    ptr_a_d = '0;
                    ptr_b_d = '0;
                end
            end
            S_SYNC: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (int'(cnt_q) == 2 * K - 1) begin
                    state_d = AFTER_FEED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                if (int'(cnt_q) == 2 * FLUSH_PAIRS - 1) begin
                    state_d = AFTER_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RDWAIT: begin
                if (int'(cnt_q) == CAP_DLY - 1) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                res_d[AW'(cnt_q)] = bus.tgt_uo_out;
                if (int'(cnt_q) == N - 1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pin values are computed from the next state so the registered pins line up with it
        feed_idx      = PW'(cnt_d >> 1);
        wr_ready_d    = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
        tgt_rst_n_d   = (state_d != S_SYNC);
        tgt_readout_d = (state_d == S_RDWAIT) || (state_d == S_CAPTURE);
        tgt_ui_in_d   = '0;
        if (state_d == S_FEED) begin
            tgt_ui_in_d = cnt_d[0] ? b_q[feed_idx] : a_q[feed_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ptr_a_q       <= '0;
            ptr_b_q       <= '0;
            a_q           <= '{default: '0};
            b_q           <= '{default: '0};
            res_q         <= '{default: '0};
            wr_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tgt_rst_n_q   <= 1'b0;
            tgt_ui_in_q   <= '0;
            tgt_readout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_a_q       <= ptr_a_d;
            ptr_b_q       <= ptr_b_d;
            a_q           <= a_d;
            b_q           <= b_d;
            res_q         <= res_d;
            wr_ready_q    <= wr_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tgt_rst_n_q   <= tgt_rst_n_d;
            tgt_ui_in_q   <= tgt_ui_in_d;
            tgt_readout_q <= tgt_readout_d;
        end
    end

    assign bus.wr_ready    = wr_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.tgt_rst_n   = tgt_rst_n_q;
    assign bus.tgt_ui_in   = tgt_ui_in_q;
    assign bus.tgt_readout = tgt_readout_q;
    assign bus.rd_data     = (int'(bus.rd_addr) < N) ? res_q[bus.rd_addr] : '0;
endmodule

// File: tb/tb_systolic_host_feeder.sv
// Bench for systolic_host_feeder: stub target counts cycles since readout rose; checks every run cycle against a model.
module tb_systolic_host_feeder;
    localparam int N     = 8;
    localparam int K     = 8;
    localparam int FP    = 16;
    localparam int CD    = 1;
    localparam int TOTAL = 1 + 2 * K + 2 * FP + CD + N + 1;

    typedef struct {
        bit       rst;
        bit [7:0] ui;
        bit       ro;
        bit       busy;
        bit       done;
        bit       rdy;
    } exp_t;

    typedef struct {
        int       addr;
        bit [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_host_feeder_if #(.N(N)) bus ();

    systolic_host_feeder #(
        .N(N), .K(K), .FLUSH_PAIRS(FP), .CAP_DLY(CD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    logic [7:0] since = 8'h00;
    logic [7:0] uo_base;
    always @(posedge clk) since <= bus.tgt_readout ? since + 8'h01 : 8'h00;
    assign bus.tgt_uo_out = uo_base + since;

    int       n_chk = 0;
    int       n_err = 0;
    bit [7:0] ma [K];
    bit [7:0] mb [K];
    int       pa = 0;
    int       pb = 0;
    logic [7:0] first_ui;
    vec_t     cap_vec [N];
    vec_t     zero_vec [N];

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h exp=%h", nm, t, act, exp);
        end
    endtask

    function automatic exp_t model_at(input int t);
        exp_t e;
        int flush0, rdw0, done_t, m;
        flush0 = 2 + 2 * K;
        rdw0   = flush0 + 2 * FP;
        done_t = rdw0 + CD + N;
        e = '{rst: 1'b1, ui: 8'h00, ro: 1'b0, busy: 1'b1, done: 1'b0, rdy: 1'b0};
        if (t == 1) begin
            e.rst = 1'b0;
        end else if (t < flush0) begin
            m    = (t - 2) / 2;
            e.ui = ((t - 2) % 2 == 0) ? ma[m] : mb[m];
        end else if (t >= rdw0 && t < done_t) begin
            e.ro = 1'b1;
        end else if (t == done_t) begin
            e.done = 1'b1;
        end else if (t > done_t) begin
            e.busy = 1'b0;
            e.rdy  = 1'b1;
        end
        return e;
    endfunction

    task automatic wr(input bit sel, input bit [7:0] data);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_sel   = sel;
        bus.wr_data  = data;
        @(posedge clk);
        #1 bus.wr_valid = 1'b0;
        if (sel) begin
            mb[pb] = data;
            pb = (pb + 1) % K;
        end else begin
            ma[pa] = data;
            pa = (pa + 1) % K;
        end
    endtask

    task automatic check_pins(input int t, input exp_t e);
        chk("tgt_rst_n", t, 32'(bus.tgt_rst_n), 32'(e.rst));
        chk("tgt_ui_in", t, 32'(bus.tgt_ui_in), 32'(e.ui));
        chk("tgt_readout", t, 32'(bus.tgt_readout), 32'(e.ro));
        chk("busy", t, 32'(bus.busy), 32'(e.busy));
        chk("done", t, 32'(bus.done), 32'(e.done));
        chk("wr_ready", t, 32'(bus.wr_ready), 32'(e.rdy));
    endtask

    task automatic do_run(input int lock_t);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        pa = 0;
        pb = 0;
        for (int t = 1; t <= TOTAL + 1; t++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.wr_valid = 1'b0;
            e = model_at(t);
            check_pins(t, e);
            if (t == 2) first_ui = bus.tgt_ui_in;
            if (t == lock_t) begin
                bus.start    = 1'b1;
                bus.wr_valid = 1'b1;
                bus.wr_sel   = 1'($urandom_range(0, 1));
                bus.wr_data  = 8'hFF;
            end
        end
        for (int i = 0; i < N; i++) begin
            bus.rd_addr = 3'(i);
            #1 chk("result", i, 32'(bus.rd_data), 32'(8'(uo_base + 8'(CD) + 8'(i))));
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            cap_vec[i]  = '{addr: i, exp: 8'(8'hA1 + i)};
            zero_vec[i] = '{addr: i, exp: 8'h00};
        end
        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_sel   = 1'b0;
        bus.wr_data  = 8'h00;
        bus.start    = 1'b0;
        bus.rd_addr  = '0;
        uo_base      = 8'h00;

        // Reset values
        repeat (3) begin
            @(negedge clk);
            chk("rst_tgt_rst_n", 0, 32'(bus.tgt_rst_n), 32'd0);
            chk("rst_readout", 0, 32'(bus.tgt_readout), 32'd0);
            chk("rst_busy", 0, 32'(bus.busy), 32'd0);
            chk("rst_done", 0, 32'(bus.done), 32'd0);
            chk("rst_wr_ready", 0, 32'(bus.wr_ready), 32'd0);
        end
        for (int i = 0; i < N; i++) begin
            bus.rd_addr = 3'(zero_vec[i].addr);
            #1 chk("rst_rd_data", i, 32'(bus.rd_data), 32'(zero_vec[i].exp));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_wr_ready", 0, 32'(bus.wr_ready), 32'd1);
        chk("rel_tgt_rst_n", 0, 32'(bus.tgt_rst_n), 32'd1);
        chk("rel_busy", 0, 32'(bus.busy), 32'd0);

        // Feed ordering and capture
        for (int i = 0; i < K; i++) wr(1'b0, 8'(i + 1));
        for (int i = 0; i < K; i++) wr(1'b1, 8'(8'h80 >> i));
        uo_base = 8'hA0;
        do_run(0);
        chk("first_ui", 2, 32'(first_ui), 32'h01);
        for (int i = 0; i < N; i++) begin
            bus.rd_addr = 3'(cap_vec[i].addr);
            #1 chk("cap_table", i, 32'(bus.rd_data), 32'(cap_vec[i].exp));
        end

        // Busy lockout then identical replay
        do_run(6);
        do_run(0);

        // Pointer wrap
        for (int i = 0; i < 9; i++) wr(1'b0, 8'(8'h11 + i));
        do_run(0);
        chk("wrap_first_a", 2, 32'(first_ui), 32'h19);

        // Asynchronous abort mid-feed
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tgt_rst_n", 0, 32'(bus.tgt_rst_n), 32'd0);
        chk("abort_ui", 0, 32'(bus.tgt_ui_in), 32'd0);
        chk("abort_readout", 0, 32'(bus.tgt_readout), 32'd0);
        chk("abort_busy", 0, 32'(bus.busy), 32'd0);
        chk("abort_done", 0, 32'(bus.done), 32'd0);
        chk("abort_wr_ready", 0, 32'(bus.wr_ready), 32'd0);
        for (int i = 0; i < N; i++) begin
            bus.rd_addr = 3'(i);
            #1 chk("abort_rd_data", i, 32'(bus.rd_data), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pa = 0;
        pb = 0;
        for (int i = 0; i < K; i++) wr(1'b0, 8'($urandom));
        for (int i = 0; i < K; i++) wr(1'b1, 8'($urandom));
        uo_base = 8'h3C;
        do_run(0);

        // Randomized runs with partial rewrites and random lockout attempts
        for (int r = 0; r < 6; r++) begin
            int na, nb;
            na = $urandom_range(1, 12);
            nb = $urandom_range(1, 12);
            for (int i = 0; i < na; i++) wr(1'b0, 8'($urandom));
            for (int i = 0; i < nb; i++) wr(1'b1, 8'($urandom));
            uo_base = 8'($urandom);
            do_run($urandom_range(0, TOTAL));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_host_feeder.md
Name: systolic_host_feeder

Overview:
- Host-side sequencer that drives the 8x8 1-bit systolic array's pin protocol from the other end.
- Buffers operand matrices A and B written by a host, then aligns the target's phase with a one-cycle synchronous reset.
- Streams interleaved A/B bytes onto the target's ui_in, flushes with zeros, asserts readout and captures the N result bytes from uo_out into a readable result buffer.
- Sits between a host bus (or test harness) and the tile's ui_in/uo_out/uio_in[0] pins.

Parameters:
- N, 8, bit width of operand/result words and number of result bytes captured.
- K, 8, operand depth: number of A and B words streamed per run.
- FLUSH_PAIRS, 16, number of zero byte-pairs driven after the operands (2*FLUSH_PAIRS cycles).
- CAP_DLY, 1, cycles from readout rising to the first capture sample.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  host operand write request.
- wr_ready  out  1  high only in IDLE.
- wr_sel  in  1  0 = write A buffer, 1 = write B buffer.
- wr_data  in  N  operand word.
- start  in  1  launch a run (sampled in IDLE only).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when results are valid.
- rd_addr  in  clog2(N)  result buffer index.
- rd_data  out  N  result word at rd_addr (combinational read).
- tgt_rst_n  out  1  drives the target's rst_n (target reset is synchronous).
- tgt_ui_in  out  N  drives the target's ui_in.
- tgt_readout  out  1  drives the target's uio_in[0].
- tgt_uo_out  in  N  target's uo_out.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state to IDLE.
  - tgt_rst_n=0, tgt_ui_in=0, tgt_readout=0, busy=0, done=0.
  - A/B write pointers=0, result buffer cleared to 0.
  - Operand buffers are not required to clear.
- Operand writes:
  - A write occurs when wr_valid && wr_ready. It stores wr_data at buf[wr_sel][ptr[wr_sel]], then that pointer increments.
  - Pointers wrap K-1 to 0; later writes overwrite earlier ones.
  - wr_valid while busy is ignored: no write, no pointer change.
  - Both pointers reset to 0 when start is accepted.
- All target-side outputs are registered and reflect the state/counters of the current cycle.
- FSM (start accepted in cycle T):
  - IDLE: tgt_rst_n=1, outputs 0. On start, go to SYNC; start outside IDLE is ignored.
  - SYNC (cycle T+1): tgt_rst_n=0, tgt_ui_in=0. Lasts 1 cycle.
  - FEED (cycles T+2 .. T+2K+1), tgt_rst_n=1:
    - even offset 2m drives A[m]; odd offset 2m+1 drives B[m].
    - This matches the target loading in1 first after its reset.
  - FLUSH: 2*FLUSH_PAIRS cycles, tgt_ui_in=0.
  - RDWAIT: tgt_readout=1, tgt_ui_in=0, CAP_DLY cycles. If CAP_DLY=0, RDWAIT is skipped.
  - CAPTURE: tgt_readout=1, N cycles. In capture cycle i, tgt_uo_out is registered into result[i].
    - Equivalently, result[i] = uo_out in cycle CAP_DLY+i, where cycle 0 is the first cycle readout is high.
  - DONE: tgt_readout=0, done=1 for 1 cycle, then IDLE.
- busy=1 from SYNC through DONE inclusive.
- Total run length: 1 + 2K + 2*FLUSH_PAIRS + CAP_DLY + N + 1 cycles after T.
- rd_data:
  - Valid at any time.
  - During CAPTURE, an entry already written shows its new value.
  - Entries not yet written show the previous run's value.
  - An out-of-range rd_addr (>= N, when N is not a power of 2) returns 0.
- Counter widths are sized for the largest count: 2K, 2*FLUSH_PAIRS, CAP_DLY, N.
- Reset mid-run:
  - Immediate abort, all outputs to reset values.
  - A partial result buffer is cleared.
  - The next start runs the full sequence.

Test Plan:
1. Reset values: hold rst_n=0 -> tgt_rst_n=0, tgt_readout=0, busy=0, done=0, wr_ready=0 during reset, wr_ready=1 after release, rd_data=0 for all addr.
2. Feed ordering (default params):
   - Stimulus: write A=0x01,0x02,...,0x08 and B=0x80,0x40,...,0x01, then pulse start at T.
   - Required: tgt_rst_n=0 only at T+1; tgt_ui_in = 0x01,0x80,0x02,0x40,...,0x08,0x01 over T+2..T+17; then 32 cycles of 0x00.
3. Capture:
   - Stimulus: stub target drives tgt_uo_out = 0xA0 + (cycles since readout rose).
   - Required: result[i]=0xA1+i (CAP_DLY=1); done pulses once at T+59; readout high exactly 9 cycles; busy low at T+60.
4. Busy lockout: start and wr_valid (data 0xFF) during FEED -> no restart, buffers unchanged, second run output identical to scenario 2.
5. Async abort: rst_n low mid-FEED for 1 cycle -> outputs reset same cycle (before next clk edge), state IDLE, results 0; new start replays the full sequence.
6. Pointer wrap: write 9 A words 0x11..0x19 -> first FEED A byte is 0x19, remaining A[1..7]=0x12..0x18.
